// File: rtl/jk_bank_driver_if.sv
// Command and bank-side bus of the JK bank excitation controller.
// slave = the controller, master = the sequencer plus the JK bank it drives.
interface jk_bank_driver_if #(
    parameter int WIDTH = 8
);
    // Handshake: a command is taken on a rising clk edge where cmd_valid and cmd_ready
    // are both high. cmd_op/cmd_data only need to be stable at that edge. There is no
    // queue, and cmd_valid while cmd_ready is low is ignored, not held.
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             bank_pr;
    logic             bank_clr;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] q_exp;
    logic             busy;
    logic             done;
    logic             err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, q_fb,
        output cmd_ready, j, k, bank_pr, bank_clr, q_exp, busy, done, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, q_fb,
        input  cmd_ready, j, k, bank_pr, bank_clr, q_exp, busy, done, err
    );
endinterface

// File: rtl/jk_bank_driver.sv
// Turns register-level commands into one cycle of hold-preferred J/K excitation for
// a JK flip-flop bank, then checks the bank's Q against a shadow copy.
module jk_bank_driver #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    jk_bank_driver_if.slave    bus,
    output logic [1:0]         o_dbg_state
);
    localparam logic [2:0] OP_LOAD   = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_INC    = 3'd2;
    localparam logic [2:0] OP_DEC    = 3'd3;
    localparam logic [2:0] OP_SHL    = 3'd4;
    localparam logic [2:0] OP_SHR    = 3'd5;
    localparam logic [2:0] OP_XOR    = 3'd6;
    localparam logic [2:0] OP_RESYNC = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] r_q_exp;
    logic             r_clr;
    logic             r_done;
    logic             r_err;
    logic             r_resync;

    logic             w_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_nxt;

    // r_clr doubles as "bank has seen at least one clear cycle since reset".
    assign w_ready  = (r_state == S_IDLE) & r_clr;
    assign w_accept = bus.cmd_valid & w_ready;

    always_comb begin
        w_nxt = r_q_exp;
        case (bus.cmd_op)
            OP_LOAD:   w_nxt = bus.cmd_data;
            OP_CLEAR:  w_nxt = '0;
            OP_INC:    w_nxt = r_q_exp + WIDTH'(1);
            OP_DEC:    w_nxt = r_q_exp - WIDTH'(1);
            OP_SHL:    w_nxt = {r_q_exp[WIDTH-2:0], bus.cmd_data[0]};
            OP_SHR:    w_nxt = {bus.cmd_data[0], r_q_exp[WIDTH-1:1]};
            OP_XOR:    w_nxt = r_q_exp ^ bus.cmd_data;
            OP_RESYNC: w_nxt = bus.q_fb;
            default:   w_nxt = r_q_exp;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_j      <= '0;
            r_k      <= '0;
            r_q_exp  <= '0;
            r_clr    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_resync <= 1'b0;
        end else begin
            r_clr  <= 1'b1;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_q_exp  <= w_nxt;
                        r_resync <= (bus.cmd_op == OP_RESYNC);
                        // Only changing bits are excited, so toggle (J=K=1) never occurs.
                        if (bus.cmd_op == OP_RESYNC) begin
                            r_j <= '0;
                            r_k <= '0;
                        end else begin
                            r_j <= ~r_q_exp & w_nxt;
                            r_k <= r_q_exp & ~w_nxt;
                        end
                        r_state <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_done <= 1'b1;
                    if (bus.q_fb != r_q_exp) begin
                        r_err <= 1'b1;
                    end else if (r_resync) begin
                        r_err <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = w_ready;
    assign bus.j         = r_j;
    assign bus.k         = r_k;
    assign bus.bank_pr   = 1'b1;
    assign bus.bank_clr  = r_clr;
    assign bus.q_exp     = r_q_exp;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: behavioural JK bank on the feedback path, directed vectors
// with fixed expected values, and randomized commands against an arithmetic model.
module tb_jk_bank_driver;
    localparam int W = 8;
    localparam int MOD = 1 << W;
    localparam logic [2:0] OP_LOAD   = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_INC    = 3'd2;
    localparam logic [2:0] OP_DEC    = 3'd3;
    localparam logic [2:0] OP_SHL    = 3'd4;
    localparam logic [2:0] OP_SHR    = 3'd5;
    localparam logic [2:0] OP_XOR    = 3'd6;
    localparam logic [2:0] OP_RESYNC = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    jk_bank_driver_if #(.WIDTH(W)) bus ();

    jk_bank_driver #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural JK bank with async-style preset/clear codes, plus a stuck-at-0 mask on Q.
    logic [W-1:0] bank_q = '0;
    logic [W-1:0] stuck_mask = '0;
    always @(posedge clk) begin
        case ({bus.bank_pr, bus.bank_clr})
            2'b10:   bank_q <= '0;
            2'b01:   bank_q <= '1;
            default: bank_q <= (bus.j & ~bank_q) | (~bus.k & bank_q);
        endcase
    end
    assign bus.q_fb = bank_q & ~stuck_mask;

    int n_cmp = 0;
    int n_fail = 0;
    logic [W-1:0] m_q;
    logic         m_err;

    typedef struct {
        logic         accepted;
        logic [W-1:0] fb;
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic [W-1:0] q;
        logic         busy_d;
        logic         done_d;
        logic [W-1:0] jk_c;
        logic         done_c;
        logic         done_i;
        logic         err_i;
    } obs_t;

    function automatic logic [W-1:0] ref_next(input logic [2:0] op, input logic [W-1:0] d,
                                              input logic [W-1:0] cur, input logic [W-1:0] fb);
        case (op)
            OP_LOAD:  return d;
            OP_CLEAR: return '0;
            OP_INC:   return W'((int'(cur) + 1) % MOD);
            OP_DEC:   return W'((int'(cur) + MOD - 1) % MOD);
            OP_SHL:   return W'((int'(cur) * 2 + int'(d[0])) % MOD);
            OP_SHR:   return W'(int'(cur) / 2 + int'(d[0]) * (MOD / 2));
            OP_XOR:   return cur ^ d;
            default:  return fb;
        endcase
    endfunction

    // Drives one command and records what the outputs showed in DRIVE, CHECK and the
    // following IDLE cycle. Entry and exit are #1 after a rising edge.
    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] d, output obs_t o);
        int waited = 0;
        o = '{default: '0};
        while (bus.cmd_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        o.accepted = (bus.cmd_ready === 1'b1);
        if (!o.accepted) return;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        o.fb          = bus.q_fb;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        o.j = bus.j; o.k = bus.k; o.q = bus.q_exp; o.busy_d = bus.busy; o.done_d = bus.done;
        @(posedge clk); #1;
        o.jk_c = bus.j | bus.k; o.done_c = bus.done;
        @(posedge clk); #1;
        o.done_i = bus.done; o.err_i = bus.err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.bank_clr, bus.cmd_ready, bus.busy, bus.done, bus.err} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_flags: clr/ready/busy/done/err=%b want 00000",
                     {bus.bank_clr, bus.cmd_ready, bus.busy, bus.done, bus.err});
        end
        n_cmp++;
        if ({bus.q_exp, bus.j, bus.k} !== 24'h0 || bus.bank_pr !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: q_exp=%h j=%h k=%h pr=%b want 00 00 00 1",
                     bus.q_exp, bus.j, bus.k, bus.bank_pr);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.bank_clr, bus.cmd_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release_pre: clr/ready=%b want 00", {bus.bank_clr, bus.cmd_ready});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.bank_clr, bus.cmd_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release_post: clr/ready=%b want 11", {bus.bank_clr, bus.cmd_ready});
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({bus.q_exp, bus.j, bus.k} !== 24'h0 || bus.cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_idle%0d: q_exp=%h j=%h k=%h ready=%b want 00 00 00 1",
                         c, bus.q_exp, bus.j, bus.k, bus.cmd_ready);
            end
        end
        m_q   = '0;
        m_err = 1'b0;
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic [W-1:0] j;
        logic [W-1:0] k;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[7];
        obs_t o;
        tbl = '{'{OP_LOAD, 8'hA5, 8'hA5, 8'hA5, 8'h00},
                '{OP_LOAD, 8'hFF, 8'hFF, 8'h5A, 8'h00},
                '{OP_INC,  8'h00, 8'h00, 8'h00, 8'hFF},
                '{OP_DEC,  8'h00, 8'hFF, 8'hFF, 8'h00},
                '{OP_LOAD, 8'h81, 8'h81, 8'h00, 8'h7E},
                '{OP_SHL,  8'h01, 8'h03, 8'h02, 8'h80},
                '{OP_SHR,  8'h00, 8'h01, 8'h00, 8'h02}};
        for (int i = 0; i < 7; i++) begin
            do_cmd(tbl[i].op, tbl[i].d, o);
            n_cmp++;
            if ({o.accepted, o.busy_d, o.j, o.k, o.q} !== {2'b11, tbl[i].j, tbl[i].k, tbl[i].q}) begin
                n_fail++;
                $display("FAIL dir%0d_jkq: acc=%b busy=%b j=%h k=%h q=%h want 1 1 %h %h %h", i,
                         o.accepted, o.busy_d, o.j, o.k, o.q, tbl[i].j, tbl[i].k, tbl[i].q);
            end
            n_cmp++;
            if ({o.done_d, o.done_c, o.done_i, o.jk_c} !== {3'b001, 8'h00}) begin
                n_fail++;
                $display("FAIL dir%0d_timing: done d/c/i=%b jk_in_check=%h want 001 00", i,
                         {o.done_d, o.done_c, o.done_i}, o.jk_c);
            end
            n_cmp++;
            if (o.err_i !== 1'b0) begin
                n_fail++;
                $display("FAIL dir%0d_err: err=%b want 0", i, o.err_i);
            end
        end
        m_q = 8'h01;
    endtask

    task automatic test_fault();
        obs_t o;
        stuck_mask = 8'h08;
        do_cmd(OP_LOAD, 8'h08, o);
        n_cmp++;
        if ({o.q, o.j, o.done_i, o.err_i} !== {8'h08, 8'h08, 2'b11}) begin
            n_fail++;
            $display("FAIL fault_detect: q=%h j=%h done=%b err=%b want 08 08 1 1",
                     o.q, o.j, o.done_i, o.err_i);
        end
        do_cmd(OP_LOAD, 8'h00, o);
        n_cmp++;
        if ({o.q, o.k, o.err_i} !== {8'h00, 8'h08, 1'b1}) begin
            n_fail++;
            $display("FAIL fault_sticky: q=%h k=%h err=%b want 00 08 1", o.q, o.k, o.err_i);
        end
        stuck_mask = '0;
        do_cmd(OP_RESYNC, 8'h5C, o);
        n_cmp++;
        if ({o.j, o.k, o.q, o.err_i} !== {8'h00, 8'h00, o.fb, 1'b0} || o.fb !== 8'h00) begin
            n_fail++;
            $display("FAIL fault_resync: j=%h k=%h q=%h fb=%h err=%b want 00 00 00 00 0",
                     o.j, o.k, o.q, o.fb, o.err_i);
        end
        m_q   = 8'h00;
        m_err = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] base;
        logic [W-1:0] want_q;
        base = m_q;
        bus.cmd_op    = OP_INC;
        bus.cmd_data  = '0;
        bus.cmd_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            want_q = W'((int'(base) + 1 + c / 3) % MOD);
            n_cmp++;
            if (bus.q_exp !== want_q || bus.done !== (c % 3 == 2)) begin
                n_fail++;
                $display("FAIL b2b_c%0d: q_exp=%h done=%b want %h %b", c, bus.q_exp, bus.done,
                         want_q, (c % 3 == 2));
            end
            if (c == 6) bus.cmd_valid = 1'b0;
        end
        m_q = W'((int'(base) + 3) % MOD);
    endtask

    task automatic test_random();
        obs_t o;
        logic [2:0]   op;
        logic [W-1:0] d;
        logic [W-1:0] nxt;
        logic [W-1:0] want_j;
        logic [W-1:0] want_k;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            d  = W'($urandom);
            if (i == 17 || i == 29) begin
                if (op == OP_RESYNC) op = OP_XOR;
                stuck_mask = W'(1 << $urandom_range(0, W - 1));
            end
            do_cmd(op, d, o);
            nxt    = ref_next(op, d, m_q, o.fb);
            want_j = (op == OP_RESYNC) ? '0 : (nxt & ~m_q);
            want_k = (op == OP_RESYNC) ? '0 : (m_q & ~nxt);
            if ((nxt & ~stuck_mask) != nxt) m_err = 1'b1;
            else if (op == OP_RESYNC) m_err = 1'b0;
            n_cmp++;
            if ({o.accepted, o.j, o.k, o.q} !== {1'b1, want_j, want_k, nxt}) begin
                n_fail++;
                $display("FAIL rnd%0d_op%0d_d%h: acc=%b j=%h k=%h q=%h want 1 %h %h %h", i, op, d,
                         o.accepted, o.j, o.k, o.q, want_j, want_k, nxt);
            end
            n_cmp++;
            if ({o.done_d, o.done_c, o.done_i, o.err_i} !== {3'b001, m_err}) begin
                n_fail++;
                $display("FAIL rnd%0d_status: done d/c/i=%b err=%b want 001 %b", i,
                         {o.done_d, o.done_c, o.done_i}, o.err_i, m_err);
            end
            stuck_mask = '0;
            m_q = nxt;
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int   done_seen = 0;
        logic [W-1:0] want_j;
        while (bus.cmd_ready !== 1'b1 && done_seen < 20) begin
            @(posedge clk); #1;
            done_seen++;
        end
        done_seen = 0;
        want_j = ~m_q & (m_q ^ 8'h0F);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_XOR;
        bus.cmd_data  = 8'h0F;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.j !== want_j) begin
            n_fail++;
            $display("FAIL mid_drive: busy=%b j=%h want 1 %h", bus.busy, bus.j, want_j);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.j, bus.k, bus.q_exp, bus.bank_clr, bus.done, bus.busy} !== {24'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL mid_reset: j=%h k=%h q=%h clr=%b done=%b busy=%b want 00 00 00 0 0 0",
                     bus.j, bus.k, bus.q_exp, bus.bank_clr, bus.done, bus.busy);
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_seen++;
        end
        n_cmp++;
        if (done_seen !== 0 || bus.bank_clr !== 1'b1 || bank_q !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_no_done: done_pulses=%0d clr=%b bank=%h want 0 1 00",
                     done_seen, bus.bank_clr, bank_q);
        end
        m_q   = '0;
        m_err = 1'b0;
        do_cmd(OP_LOAD, 8'h3C, o);
        n_cmp++;
        if ({o.accepted, o.j, o.k, o.q, o.done_i, o.err_i} !== {1'b1, 8'h3C, 8'h00, 8'h3C, 2'b10}) begin
            n_fail++;
            $display("FAIL mid_recover: acc=%b j=%h k=%h q=%h done=%b err=%b want 1 3c 00 3c 1 0",
                     o.accepted, o.j, o.k, o.q, o.done_i, o.err_i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = '0;
        m_q           = '0;
        m_err         = 1'b0;
        test_reset();
        test_directed();
        test_fault();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
